// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter sharing one fifo_sync write port
// between NUM_REQ producers. Each grant lasts up to MAX_BURST beats and
// writes are suppressed while the FIFO reports full.
module fifo_wr_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4,
  parameter int IDX_WIDTH = 2,
  parameter int CNT_WIDTH = 3
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [NUM_REQ-1:0]       req_i,
  input  logic [NUM_REQ*WIDTH-1:0] wdata_i,
  output logic [NUM_REQ-1:0]       gnt_o,
  output logic [NUM_REQ-1:0]       ack_o,
  output logic                     fifo_wr_en_o,
  output logic [WIDTH-1:0]         fifo_wdata_o,
  input  logic                     fifo_full_i,
  output logic [IDX_WIDTH-1:0]     owner_o,
  output logic                     busy_o
);

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } state_t;

  state_t               state_reg, state_next;
  logic [NUM_REQ-1:0]   gnt_reg, gnt_next;
  logic [IDX_WIDTH-1:0] owner_reg, owner_next;
  logic [IDX_WIDTH-1:0] last_owner_reg, last_owner_next;
  logic [CNT_WIDTH-1:0] cnt_reg, cnt_next;

  logic [WIDTH-1:0]     slice [NUM_REQ];
  logic [NUM_REQ-1:0]   owner_sel;
  logic [WIDTH-1:0]     owner_data;
  logic                 owner_req;
  logic                 beat;
  logic                 last_beat;
  logic                 win_found;
  logic [IDX_WIDTH-1:0] win_idx;

  // Per-producer data slices and a one-hot decode of the current owner, so
  // the owner mux never indexes past NUM_REQ.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_prod
      assign slice[gi]     = wdata_i[gi*WIDTH +: WIDTH];
      assign owner_sel[gi] = (owner_reg == IDX_WIDTH'(gi));
    end
  endgenerate

  assign owner_req = |(req_i & owner_sel);
  assign last_beat = (cnt_reg == CNT_WIDTH'(MAX_BURST - 1));

  // Select the owner's data slice.
  always_comb begin
    owner_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (owner_sel[i]) begin
        owner_data = slice[i];
      end
    end
  end

  // Round-robin search: first requester after last_owner, wrapping around,
  // so the previous owner is always considered last.
  always_comb begin
    int cand;
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = (int'(last_owner_reg) + k) % NUM_REQ;
      if (!win_found && req_i[cand]) begin
        win_found = 1'b1;
        win_idx   = IDX_WIDTH'(cand);
      end
    end
  end

  // FIFO-side outputs: only the owner may write, and only while not full.
  always_comb begin
    beat         = 1'b0;
    ack_o        = '0;
    fifo_wr_en_o = 1'b0;
    fifo_wdata_o = '0;
    if (state_reg == OWN) begin
      fifo_wdata_o = owner_data;
      beat         = owner_req & ~fifo_full_i;
      fifo_wr_en_o = beat;
      ack_o        = beat ? owner_sel : '0;
    end
  end

  // Next-state logic: grant on any request in IDLE, release on request drop
  // or on the final beat of a burst.
  always_comb begin
    state_next      = state_reg;
    gnt_next        = gnt_reg;
    owner_next      = owner_reg;
    last_owner_next = last_owner_reg;
    cnt_next        = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (win_found) begin
          state_next = OWN;
          owner_next = win_idx;
          cnt_next   = '0;
          for (int i = 0; i < NUM_REQ; i++) begin
            gnt_next[i] = (IDX_WIDTH'(i) == win_idx);
          end
        end
      end
      OWN: begin
        if (beat) begin
          cnt_next = cnt_reg + 1'b1;
        end
        if (!owner_req || (beat && last_beat)) begin
          state_next      = IDLE;
          gnt_next        = '0;
          last_owner_next = owner_reg;
          cnt_next        = '0;
        end
      end
      default: begin
        state_next = IDLE;
        gnt_next   = '0;
      end
    endcase
  end

  // State registers; reset makes producer 0 the highest priority.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg      <= IDLE;
      gnt_reg        <= '0;
      owner_reg      <= '0;
      last_owner_reg <= IDX_WIDTH'(NUM_REQ - 1);
      cnt_reg        <= '0;
    end else begin
      state_reg      <= state_next;
      gnt_reg        <= gnt_next;
      owner_reg      <= owner_next;
      last_owner_reg <= last_owner_next;
      cnt_reg        <= cnt_next;
    end
  end

  assign gnt_o   = gnt_reg;
  assign owner_o = owner_reg;
  assign busy_o  = (state_reg == OWN);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: directed phases plus random traffic, checked against
// a behavioural owner/queue model and a per-producer FIFO scoreboard.
module tb_fifo_wr_arbiter;
  localparam int N     = 4;
  localparam int W     = 8;
  localparam int MB    = 4;
  localparam int DEPTH = 16;

  logic           clk_i       = 1'b0;
  logic           rst_ni      = 1'b0;
  logic [N-1:0]   req_i       = '0;
  logic [N*W-1:0] wdata_i     = '0;
  logic           fifo_full_i = 1'b0;
  logic [N-1:0]   gnt_o;
  logic [N-1:0]   ack_o;
  logic           fifo_wr_en_o;
  logic [W-1:0]   fifo_wdata_o;
  logic [1:0]     owner_o;
  logic           busy_o;

  fifo_wr_arbiter #(
    .NUM_REQ(N), .WIDTH(W), .MAX_BURST(MB), .IDX_WIDTH(2), .CNT_WIDTH(3)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .wdata_i(wdata_i),
    .gnt_o(gnt_o), .ack_o(ack_o), .fifo_wr_en_o(fifo_wr_en_o),
    .fifo_wdata_o(fifo_wdata_o), .fifo_full_i(fifo_full_i),
    .owner_o(owner_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  int checks   = 0;
  int failures = 0;

  // Reference model: owner index (-1 = nobody), previous owner, beats taken.
  int m_owner = -1;
  int m_last  = N - 1;
  int m_beats = 0;
  int cur[N];      // items acknowledged per producer (next item to offer)
  int want[N];     // beats each producer still wants in directed phases
  int exp_seq[N];  // next item expected out of the FIFO per producer
  bit   rand_mode  = 1'b0;
  logic rst_drive  = 1'b0;

  logic [7:0] fifo_q[$];
  bit         fifo_pre[$];

  int phase_cyc;
  int wr_seen;
  int ack_cnt[N];
  int ack0_log[$];
  int grant_log[$];
  int grant_cyc[$];
  logic [N-1:0] prev_gnt = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] pdata(input int n);
    logic [7:0] d;
    d[7:6] = n[1:0];
    d[5:0] = cur[n][5:0];
    return d;
  endfunction

  task automatic clear_stats();
    phase_cyc = 0;
    wr_seen   = 0;
    for (int n = 0; n < N; n++) ack_cnt[n] = 0;
    ack0_log.delete();
    grant_log.delete();
    grant_cyc.delete();
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_last  = N - 1;
    m_beats = 0;
  endtask

  // One clock cycle: drive at the falling edge, check 1 time unit later,
  // then advance the model and the FIFO to what the next rising edge does.
  task automatic step(input bit rd);
    logic [N-1:0] req, exp_gnt, exp_ack;
    logic [7:0]   exp_wd, d;
    logic         exp_we, exp_busy, full;
    logic [5:0]   e;
    bit           found, pre;
    int           c, id;
    for (int n = 0; n < N; n++) begin
      if (rand_mode) req[n] = ($urandom_range(0, 99) < 65);
      else           req[n] = (want[n] > 0);
    end
    @(negedge clk_i);
    rst_ni = rst_drive;
    req_i  = req;
    for (int n = 0; n < N; n++) wdata_i[n*W +: W] = pdata(n);
    full        = (fifo_q.size() >= DEPTH);
    fifo_full_i = full;
    #1;
    if (!rst_drive) model_reset();
    exp_gnt = '0; exp_ack = '0; exp_we = 1'b0; exp_wd = '0; exp_busy = 1'b0;
    if (m_owner >= 0) begin
      exp_busy         = 1'b1;
      exp_gnt[m_owner] = 1'b1;
      exp_wd           = pdata(m_owner);
      if (req[m_owner] && !full) begin
        exp_we           = 1'b1;
        exp_ack[m_owner] = 1'b1;
      end
    end
    chk("gnt", gnt_o, exp_gnt);
    chk("ack", ack_o, exp_ack);
    chk("wr_en", fifo_wr_en_o, exp_we);
    chk("wdata", fifo_wdata_o, exp_wd);
    chk("busy", busy_o, exp_busy);
    chk("ack_onehot0", $onehot0(ack_o), 1);
    chk("wr_error", fifo_wr_en_o & full, 0);
    if (m_owner >= 0) chk("owner", owner_o, m_owner[1:0]);
    // Observed-behaviour logs for the directed phase checks.
    if (fifo_wr_en_o === 1'b1) begin
      wr_seen++;
      $display("wr t=%0t cyc=%0d data=%02h gnt=%b", $time, phase_cyc, fifo_wdata_o, gnt_o);
    end
    for (int n = 0; n < N; n++) if (ack_o[n] === 1'b1) ack_cnt[n]++;
    if (ack_o[0] === 1'b1) ack0_log.push_back(phase_cyc);
    if (gnt_o !== '0 && prev_gnt === '0) begin
      for (int n = 0; n < N; n++) begin
        if (gnt_o[n] === 1'b1) begin
          grant_log.push_back(n);
          grant_cyc.push_back(phase_cyc);
        end
      end
    end
    prev_gnt = gnt_o;
    // Model advance.
    if (rst_drive) begin
      if (m_owner < 0) begin
        found = 1'b0;
        for (int k = 1; k <= N; k++) begin
          c = (m_last + k) % N;
          if (!found && req[c]) begin
            found   = 1'b1;
            m_owner = c;
            m_beats = 0;
          end
        end
      end else begin
        if (exp_we) begin
          m_beats++;
          cur[m_owner]++;
          if (want[m_owner] > 0) want[m_owner]--;
        end
        if (!req[m_owner] || m_beats == MB) begin
          m_last  = m_owner;
          m_owner = -1;
        end
      end
    end
    // FIFO model: read first, then accept the write.
    if (rd && fifo_q.size() > 0) begin
      d   = fifo_q.pop_front();
      pre = fifo_pre.pop_front();
      if (!pre) begin
        id = int'(d[7:6]);
        e  = exp_seq[id][5:0];
        chk("fifo_order", d, {d[7:6], e});
        exp_seq[id]++;
      end
    end
    if (fifo_wr_en_o === 1'b1 && fifo_q.size() < DEPTH) begin
      fifo_q.push_back(fifo_wdata_o);
      fifo_pre.push_back(1'b0);
    end
    phase_cyc++;
  endtask

  initial begin
    for (int n = 0; n < N; n++) begin
      cur[n] = 0; want[n] = 0; exp_seq[n] = 0;
    end
    clear_stats();

    // Reset state.
    rst_drive = 1'b0;
    step(1'b0);
    step(1'b0);
    chk("rst_owner", owner_o, 0);
    rst_drive = 1'b1;

    // Single producer: 4-beat burst, bubble, regrant, 2 beats.
    clear_stats();
    want[0] = 6;
    for (int i = 0; i < 10; i++) step(1'b1);
    chk("single_gnt_cyc", grant_cyc.size() > 0 ? grant_cyc[0] : -1, 1);
    chk("single_acks", ack0_log.size(), 6);
    if (ack0_log.size() == 6) begin
      chk("single_ack0", ack0_log[0], 1);
      chk("single_ack3", ack0_log[3], 4);
      chk("single_ack4", ack0_log[4], 6);
      chk("single_ack5", ack0_log[5], 7);
    end

    // Fairness from reset with all producers requesting.
    rst_drive = 1'b0;
    step(1'b1);
    rst_drive = 1'b1;
    clear_stats();
    for (int n = 0; n < N; n++) want[n] = 1000;
    for (int i = 0; i < 40; i++) step(1'b1);
    for (int n = 0; n < N; n++) want[n] = 0;
    chk("fair_writes", wr_seen, 32);
    chk("fair_grants", grant_log.size(), 8);
    if (grant_log.size() == 8) begin
      for (int g = 0; g < 8; g++) chk("fair_order", grant_log[g], g % N);
    end
    for (int n = 0; n < N; n++) chk("fair_beats", ack_cnt[n], 8);
    for (int i = 0; i < 20; i++) step(1'b1);

    // Full stall: 14 entries preloaded into a 16-deep FIFO.
    fifo_q.delete();
    fifo_pre.delete();
    for (int i = 0; i < 14; i++) begin
      fifo_q.push_back(8'hEE);
      fifo_pre.push_back(1'b1);
    end
    clear_stats();
    want[1] = 3;
    for (int i = 0; i < 8; i++) step(1'b0);
    chk("stall_writes", wr_seen, 2);
    chk("stall_gnt", gnt_o, 4'b0010);
    chk("stall_ack", ack_o, 0);
    step(1'b1);
    for (int i = 0; i < 4; i++) step(1'b0);
    chk("stall_after_read", wr_seen, 3);
    for (int i = 0; i < 20; i++) step(1'b1);

    // Early release: producer 2 drops after 2 beats, producer 3 follows.
    clear_stats();
    want[2] = 2;
    want[3] = 3;
    for (int i = 0; i < 10; i++) step(1'b1);
    chk("early_ack2", ack_cnt[2], 2);
    chk("early_ack3", ack_cnt[3], 3);
    chk("early_grants", grant_log.size(), 2);
    if (grant_log.size() == 2) begin
      chk("early_first", grant_log[0], 2);
      chk("early_second", grant_log[1], 3);
      chk("early_second_cyc", grant_cyc[1], 5);
    end

    // Asynchronous reset in the middle of producer 2's burst.
    clear_stats();
    want[2] = 4;
    for (int i = 0; i < 3; i++) step(1'b1);
    chk("mid_acks", ack_cnt[2], 2);
    @(negedge clk_i);
    req_i = 4'b0100;
    wdata_i[2*W +: W] = pdata(2);
    fifo_full_i = (fifo_q.size() >= DEPTH);
    #1;
    chk("pre_rst_we", fifo_wr_en_o, 1);
    #1;
    rst_ni = 1'b0;
    #1;
    chk("async_gnt", gnt_o, 0);
    chk("async_busy", busy_o, 0);
    chk("async_we", fifo_wr_en_o, 0);
    chk("async_ack", ack_o, 0);
    model_reset();
    rst_drive = 1'b0;
    want[2] = 2;
    want[3] = 2;
    step(1'b1);
    rst_drive = 1'b1;
    clear_stats();
    for (int i = 0; i < 10; i++) step(1'b1);
    chk("rst_grants", grant_log.size(), 2);
    if (grant_log.size() == 2) begin
      chk("rst_first", grant_log[0], 2);
      chk("rst_second", grant_log[1], 3);
    end
    for (int i = 0; i < 20; i++) step(1'b1);

    // Concurrent random traffic with random FIFO reads.
    clear_stats();
    rand_mode = 1'b1;
    for (int i = 0; i < 200; i++) step(1'($urandom_range(0, 1)));
    rand_mode = 1'b0;
    for (int n = 0; n < N; n++) want[n] = 0;
    for (int i = 0; i < 30; i++) step(1'b1);
    chk("drain_empty", fifo_q.size(), 0);
    chk("drain_idle", busy_o, 0);
    for (int n = 0; n < N; n++) chk("scoreboard_count", exp_seq[n], cur[n]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
